// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: prefetches sequential bytes over a req/ack memory port into a small
// FIFO and presents the byte matching the datapath PC; any PC departure flushes and refetches.
module instr_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] pc,
  input  logic       advance,
  output logic [7:0] instruction,
  output logic       valid,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [7:0]    fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_addr_q, head_addr_d, fetch_addr_q, fetch_addr_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d, outstanding_q, outstanding_d, discard_q, discard_d;

  logic          redirect, ack, push, pop, issue;
  logic [CW:0]   credit;

  always_comb begin
    redirect    = pc != head_addr_q;
    valid       = (count_q != '0) && !redirect;
    instruction = valid ? fifo_q[rd_ptr_q] : 8'h00;
    ack         = mem_ack && mem_req_q;
    // A response landing in the redirect cycle belongs to the old stream, so it is dropped too.
    push        = ack && !discard_q && !redirect;
    pop         = valid && advance;
    credit      = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
    issue       = !mem_req_q && (credit < CREDIT_MAX) && !redirect;
  end

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    head_addr_d   = head_addr_q;
    fetch_addr_d  = fetch_addr_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (redirect) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      head_addr_d  = pc;
      fetch_addr_d = pc;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        head_addr_d = head_addr_q + 8'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (issue) fetch_addr_d = fetch_addr_q + 8'd1;
    end

    if (issue) begin
      mem_req_d     = 1'b1;
      mem_addr_d    = fetch_addr_q;
      outstanding_d = 1'b1;
    end else if (ack) begin
      mem_req_d     = 1'b0;
      outstanding_d = 1'b0;
    end

    // An ack in the redirect cycle retires the stale request itself; nothing is left to discard.
    if (redirect)  discard_d = outstanding_q && !ack;
    else if (ack)  discard_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      head_addr_q   <= 8'h00;
      fetch_addr_q  <= 8'h00;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 8'h00;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      head_addr_q   <= head_addr_d;
      fetch_addr_q  <= fetch_addr_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= mem_data;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule
